// File: rtl/axi_mem_slave_pkg.sv
// Shared types and constants for the axi_mem_slave AXI memory responder.
package axi_mem_slave_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2,
        RD_DATA = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Number of byte-offset bits below the word index for a given beat width.
    function automatic int unsigned ofs_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi_mem_slave_fifo.sv
// Two-entry valid/ready FIFO with synchronous flush; holds {rdata, rlast}
// for the read data channel. Output data reads as zero while empty.
module axi_mem_slave_fifo #(
    parameter int unsigned WIDTH = 257
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] slot_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = out_valid_o ? slot_q[rd_ptr_q] : '0;
    assign count_o     = count_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Pointer and occupancy registers; flush empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data slots; contents are don't-care while not counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI responder backed by an inferred block RAM. One burst outstanding at a
// time, round-robin between write and read address channels.
// Optional macro AXI_MEM_SLAVE_WSTRB_EN enables per-byte write strobes.
module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int unsigned MEM_AWIDTH     = 10,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_LEN_WIDTH  = 8,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_ID_WIDTH-1:0]     axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [AXI_LEN_WIDTH-1:0]    axi_awlen,
    input  logic                        axi_awvalid,
    output logic                        axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                        axi_wlast,
    input  logic                        axi_wvalid,
    output logic                        axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     axi_bid,
    output logic [1:0]                  axi_bresp,
    output logic                        axi_bvalid,
    input  logic                        axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [AXI_LEN_WIDTH-1:0]    axi_arlen,
    input  logic                        axi_arvalid,
    output logic                        axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                  axi_rresp,
    output logic                        axi_rlast,
    output logic                        axi_rvalid,
    input  logic                        axi_rready
);

    localparam int unsigned OFS    = ofs_bits(AXI_DATA_WIDTH);
    localparam int unsigned NBYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned DEPTH  = 1 << MEM_AWIDTH;
    localparam int unsigned LW     = AXI_LEN_WIDTH;

    state_e                    state_q, state_d;
    logic                      last_wr_q, last_wr_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [LW-1:0]             len_q, len_d;
    logic [MEM_AWIDTH-1:0]     ptr_q, ptr_d;
    logic [LW-1:0]             beat_q, beat_d;
    logic                      err_q, err_d;
    logic [LW:0]               issued_q, issued_d;
    logic                      inflight_q, inflight_d;
    logic                      rlast_pend_q, rlast_pend_d;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
    logic [AXI_DATA_WIDTH-1:0] ram_rdata_q;
    logic [MEM_AWIDTH-1:0]     rd_addr;
    logic                      mem_we, rd_issue;
    logic                      grant_wr;
    logic [1:0]                fifo_count;
    logic [2:0]                in_use;
    logic                      fifo_in_ready;
    logic                      r_pop;

    assign r_pop     = axi_rvalid && axi_rready;
    assign in_use    = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign grant_wr  = axi_awvalid && (!axi_arvalid || !last_wr_q);
    assign axi_bid   = id_q;
    assign axi_bresp = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_rid   = id_q;
    assign axi_rresp = RESP_OKAY;

    // Arbitration, burst bookkeeping and channel handshakes.
    // The first read beat is issued to RAM in the AR handshake cycle, and a
    // beat popped this cycle frees its FIFO slot, so reads stream without gaps.
    always_comb begin
        state_d      = state_q;
        last_wr_d    = last_wr_q;
        id_d         = id_q;
        len_d        = len_q;
        ptr_d        = ptr_q;
        beat_d       = beat_q;
        err_d        = err_q;
        issued_d     = issued_q;
        inflight_d   = 1'b0;
        rlast_pend_d = rlast_pend_q;
        rd_addr      = ptr_q;
        mem_we       = 1'b0;
        rd_issue     = 1'b0;
        axi_awready  = 1'b0;
        axi_arready  = 1'b0;
        axi_wready   = 1'b0;
        axi_bvalid   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && grant_wr) begin
                    axi_awready = 1'b1;
                    id_d        = axi_awid;
                    len_d       = axi_awlen;
                    ptr_d       = axi_awaddr[MEM_AWIDTH+OFS-1:OFS];
                    beat_d      = '0;
                    err_d       = 1'b0;
                    last_wr_d   = 1'b1;
                    state_d     = WR_DATA;
                end else if (!rst && axi_arvalid) begin
                    axi_arready  = 1'b1;
                    id_d         = axi_arid;
                    len_d        = axi_arlen;
                    rd_addr      = axi_araddr[MEM_AWIDTH+OFS-1:OFS];
                    rd_issue     = 1'b1;
                    ptr_d        = rd_addr + 1'b1;
                    issued_d     = {{LW{1'b0}}, 1'b1};
                    inflight_d   = 1'b1;
                    rlast_pend_d = (axi_arlen == '0);
                    last_wr_d    = 1'b0;
                    state_d      = RD_DATA;
                end
            end
            WR_DATA: begin
                axi_wready = 1'b1;
                if (axi_wvalid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (axi_wlast != (beat_q == len_q)) begin
                        err_d = 1'b1;
                    end
                    if (beat_q == len_q) begin
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready) begin
                    state_d = IDLE;
                end
            end
            RD_DATA: begin
                if ((issued_q <= {1'b0, len_q}) && ((in_use < 3'd2) || r_pop)) begin
                    rd_issue     = 1'b1;
                    ptr_d        = ptr_q + 1'b1;
                    issued_d     = issued_q + 1'b1;
                    inflight_d   = 1'b1;
                    rlast_pend_d = (issued_q[LW-1:0] == len_q);
                end
                if (r_pop && axi_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_wr_q    <= 1'b0;
            id_q         <= '0;
            len_q        <= '0;
            ptr_q        <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            issued_q     <= '0;
            inflight_q   <= 1'b0;
            rlast_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_wr_q    <= last_wr_d;
            id_q         <= id_d;
            len_q        <= len_d;
            ptr_q        <= ptr_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            issued_q     <= issued_d;
            inflight_q   <= inflight_d;
            rlast_pend_q <= rlast_pend_d;
        end
    end

    // Block RAM: write port and registered read port, contents not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
`ifdef AXI_MEM_SLAVE_WSTRB_EN
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (axi_wstrb[b]) begin
                    mem[ptr_q][b*8 +: 8] <= axi_wdata[b*8 +: 8];
                end
            end
`else
            mem[ptr_q] <= axi_wdata;
`endif
        end
        if (rd_issue) begin
            ram_rdata_q <= mem[rd_addr];
        end
    end

    axi_mem_slave_fifo #(
        .WIDTH (AXI_DATA_WIDTH + 1)
    ) u_rfifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (state_q != RD_DATA),
        .in_data_i   ({ram_rdata_q, rlast_pend_q}),
        .in_valid_i  (inflight_q),
        .in_ready_o  (fifo_in_ready),
        .out_data_o  ({axi_rdata, axi_rlast}),
        .out_valid_o (axi_rvalid),
        .out_ready_i (axi_rready),
        .count_o     (fifo_count)
    );

    logic unused_bits;
    assign unused_bits = ^{axi_awaddr, axi_araddr, axi_wstrb, fifo_in_ready, NBYTES[0]};

endmodule
